// File: rtl/aes_dispatch_pkg.sv
// Shared types and defaults for the multi-channel AES dispatcher.
// Holds the mode encoding, the request/response records and a sizing helper.
package aes_dispatch_pkg;

    localparam int AES_NUM_CH = 4;
    localparam int AES_DATA_W = 128;
    localparam int AES_KEY_W  = 128;
    localparam int AES_CH_W   = $clog2(AES_NUM_CH);

    typedef enum logic {
        AES_DECRYPT = 1'b0,
        AES_ENCRYPT = 1'b1
    } aes_mode_e;

    typedef struct packed {
        logic [AES_DATA_W-1:0] text;
        logic [AES_KEY_W-1:0]  key;
        aes_mode_e             mode;
    } aes_req_t;

    typedef struct packed {
        logic [AES_DATA_W-1:0] text;
        logic [AES_CH_W-1:0]   ch;
    } aes_rsp_t;

    // Smallest power of two that is >= n (n >= 1).
    function automatic int pow2_ceil(input int n);
        int p;
        p = 1;
        while (p < n) p = p * 2;
        return p;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer just past the winner whenever the grant is consumed.
module aes_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] ptr_next;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;
    logic            found;

    // Search order ptr, ptr+1, ... wrapping at NUM_CH (not necessarily a power of 2).
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, ptr_reg} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            cand = sum[CH_W-1:0];
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

    assign ptr_next = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/aes_channel_dispatcher.sv
// Multi-channel front end for a fixed-latency, non-stallable AES core: round-robin
// issue with channel tagging, in-order result buffering and credit-based flow control.
module aes_channel_dispatcher
    import aes_dispatch_pkg::*;
#(
    parameter int NUM_CH    = AES_NUM_CH,
    parameter int DATA_W    = AES_DATA_W,
    parameter int KEY_W     = AES_KEY_W,
    parameter int CORE_LAT  = 11,
    parameter int OUT_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         s_valid,
    output logic [NUM_CH-1:0]         s_ready,
    input  logic [NUM_CH*DATA_W-1:0]  s_text,
    input  logic [NUM_CH*KEY_W-1:0]   s_key,
    input  logic [NUM_CH-1:0]         s_flag,
    output logic                      core_valid_in,
    output logic [DATA_W-1:0]         core_text,
    output logic [KEY_W-1:0]          core_key,
    output logic                      core_flag,
    input  logic                      core_valid_out,
    input  logic [DATA_W-1:0]         core_text_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_text,
    output logic [$clog2(NUM_CH)-1:0] m_ch,
    output logic                      err_unexp
);

    localparam int CH_W      = $clog2(NUM_CH);
    localparam int OUT_PW    = $clog2(OUT_DEPTH);
    // The core holds at most CORE_LAT+1 tags at once, so the tag ring never needs more.
    localparam int TAG_DEPTH = (pow2_ceil(CORE_LAT + 1) < OUT_DEPTH) ?
                               pow2_ceil(CORE_LAT + 1) : OUT_DEPTH;
    localparam int TAG_PW    = $clog2(TAG_DEPTH);

    logic [DATA_W-1:0] ch_text [NUM_CH];
    logic [KEY_W-1:0]  ch_key  [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_text[gi] = s_text[gi*DATA_W +: DATA_W];
            assign ch_key[gi]  = s_key[gi*KEY_W +: KEY_W];
        end
    endgenerate

    // ---------------- credit and arbitration ----------------
    logic [OUT_PW:0]   outstanding_reg;
    logic              credit_ok;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              accept;
    logic              m_fire;

    assign credit_ok = (outstanding_reg < (OUT_PW+1)'(OUT_DEPTH));
    assign arb_req   = s_valid & {NUM_CH{credit_ok & ~rst}};
    assign s_ready   = grant;
    assign accept    = |grant;

    aes_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant),
        .idx     (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else begin
            case ({accept, m_fire})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // ---------------- issue register ----------------
    aes_req_t req_reg;
    logic     core_valid_in_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            core_valid_in_reg <= 1'b0;
            req_reg           <= '0;
        end else begin
            core_valid_in_reg <= accept;
            if (accept) begin
                req_reg.text <= ch_text[grant_idx];
                req_reg.key  <= ch_key[grant_idx];
                req_reg.mode <= aes_mode_e'(s_flag[grant_idx]);
            end
        end
    end

    assign core_valid_in = core_valid_in_reg;
    assign core_text     = req_reg.text;
    assign core_key      = req_reg.key;
    assign core_flag     = req_reg.mode;

    // ---------------- tag ring (one entry per request inside the core) ----------------
    logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
    logic [TAG_PW-1:0] tag_wr_ptr_reg;
    logic [TAG_PW-1:0] tag_rd_ptr_reg;
    logic [TAG_PW:0]   tag_cnt_reg;
    logic              tag_empty;
    logic              tag_pop;
    logic              err_unexp_reg;

    assign tag_empty = (tag_cnt_reg == '0);
    assign tag_pop   = core_valid_out & ~tag_empty;

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_ptr_reg] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            tag_cnt_reg    <= '0;
            err_unexp_reg  <= 1'b0;
        end else begin
            if (accept) tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
            if (tag_pop) tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
            case ({accept, tag_pop})
                2'b10:   tag_cnt_reg <= tag_cnt_reg + 1'b1;
                2'b01:   tag_cnt_reg <= tag_cnt_reg - 1'b1;
                default: tag_cnt_reg <= tag_cnt_reg;
            endcase
            if (core_valid_out && tag_empty) err_unexp_reg <= 1'b1;
        end
    end

    assign err_unexp = err_unexp_reg;

    // ---------------- output ring ----------------
    aes_rsp_t          out_mem [OUT_DEPTH];
    logic [OUT_PW-1:0] out_wr_ptr_reg;
    logic [OUT_PW-1:0] out_rd_ptr_reg;
    logic [OUT_PW:0]   out_cnt_reg;
    aes_rsp_t          out_head;

    always_ff @(posedge clk) begin
        if (tag_pop) begin
            out_mem[out_wr_ptr_reg] <= '{text: core_text_out, ch: tag_mem[tag_rd_ptr_reg]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_cnt_reg    <= '0;
        end else begin
            if (tag_pop) out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
            if (m_fire) out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
            case ({tag_pop, m_fire})
                2'b10:   out_cnt_reg <= out_cnt_reg + 1'b1;
                2'b01:   out_cnt_reg <= out_cnt_reg - 1'b1;
                default: out_cnt_reg <= out_cnt_reg;
            endcase
        end
    end

    // Head is shown directly from the ring, so it stays put while m_ready is low.
    assign out_head = out_mem[out_rd_ptr_reg];
    assign m_valid  = (out_cnt_reg != '0) & ~rst;
    assign m_fire   = m_valid & m_ready;
    assign m_text   = out_head.text;
    assign m_ch     = out_head.ch;

endmodule
